immediate_encoder: RTL and testbench

IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

---
 rtl/immediate_encoder_pkg.sv | 64 ++++++
 rtl/rotate_left32.sv | 26 ++
 rtl/immediate_encoder.sv | 139 +++++++++++++
 tb/tb_immediate_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/immediate_encoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : immediate_defs                                             |
// | Description : Shared definitions for the immediate encoder and the       |
// |               immediate extender: mode codes, FSM state encodings, the   |
// |               per-evaluation result record and the reference extender    |
// |               function that maps an encoded field back to 32 bits.      |
// | Contents    : SEL_* mode codes, ST_* state codes, eval_result_t,         |
// |               extend_immediate()                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package immediate_defs;

   // Encoding modes carried on immediate_sel
   localparam logic [1:0] SEL_MEM    = 2'd0;  // 12-bit unsigned memory offset
   localparam logic [1:0] SEL_ROT    = 2'd1;  // imm8 rotated right by 2*rot
   localparam logic [1:0] SEL_BRANCH = 2'd2;  // signed word-aligned 26-bit offset
   localparam logic [1:0] SEL_RSVD   = 2'd3;  // reserved, never encodable

   // Encoder FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EVAL = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Outcome of one EVAL cycle: finished flag, encodability and field value
   typedef struct packed {
      logic        fin;
      logic        valid;
      logic [23:0] imm;
   } eval_result_t;

   // Expands an encoded field back to the 32-bit value it stands for.
   // Mode 1 undoes the encoder's left rotate with a right rotate of the
   // same even amount.
   function automatic logic [31:0] extend_immediate(input logic [1:0]  sel,
                                                    input logic [23:0] imm);
      logic [63:0] dbl;
      logic [4:0]  amt;
      logic [31:0] res;
      dbl = 64'h0;
      amt = 5'd0;
      res = 32'h0;
      case (sel)
         SEL_MEM: begin
            res = {20'h00000, imm[11:0]};
         end
         SEL_ROT: begin
            amt = {imm[11:8], 1'b0};
            dbl = {24'h000000, imm[7:0], 24'h000000, imm[7:0]} >> amt;
            res = dbl[31:0];
         end
         SEL_BRANCH: begin
            res = {{6{imm[23]}}, imm, 2'b00};
         end
         default: begin
            res = 32'h0;
         end
      endcase
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rotate_left32.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rotate_left32                                              |
// | Description : Purely combinational 32-bit rotate-left. Bits shifted out  |
// |               of bit 31 re-enter at bit 0.                               |
// | Ports       : i_value  [31:0] value to rotate                            |
// |               i_amount [4:0]  rotate distance in bits (0..31)            |
// |               o_value  [31:0] rotated value                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rotate_left32 (
   input  logic [31:0] i_value,
   input  logic [4:0]  i_amount,
   output logic [31:0] o_value
);

   logic [63:0] w_doubled;

   // Shifting two back-to-back copies left leaves the wrapped bits in the
   // low end of the upper half, which avoids a 32-bit shift-by-32 corner.
   assign w_doubled = {i_value, i_value} << i_amount;
   assign o_value   = w_doubled[63:32];

endmodule

`default_nettype wire

// File: rtl/immediate_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : immediate_encoder                                          |
// | Description : Compresses a 32-bit value into a 24-bit instruction        |
// |               immediate field. Modes: 0 memory offset, 1 rotated imm8    |
// |               (sequential search over rotate amounts), 2 branch offset,  |
// |               3 reserved. Three-state FSM IDLE -> EVAL -> DONE.          |
// | Parameters  : ROT_STEPS - rotate candidates searched in mode 1 (1..16)   |
// | Ports       : clk              system clock, rising edge                 |
// |               rst_n            asynchronous active-low reset             |
// |               start            request, sampled only in IDLE             |
// |               in_value [31:0]  value to encode                           |
// |               immediate_sel[1:0] encoding mode                           |
// |               busy             FSM not in IDLE                           |
// |               done             one-cycle result-available pulse          |
// |               valid            value was encodable (held after done)     |
// |               out_immediate_24 [23:0] encoded field (held after done)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module immediate_encoder
   import immediate_defs::*;
#(
   parameter int ROT_STEPS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] in_value,
   input  logic [1:0]  immediate_sel,
   output logic        busy,
   output logic        done,
   output logic        valid,
   output logic [23:0] out_immediate_24
);

   // The rot field in the encoding is 4 bits wide, so the search counter is
   // too; ROT_STEPS above 16 is not meaningful for this format.
   localparam logic [3:0] c_ROT_LAST = 4'(ROT_STEPS - 1);

   logic [1:0]   r_state;
   logic [3:0]   r_rot;
   logic [31:0]  r_value;
   logic [1:0]   r_sel;
   logic         r_valid;
   logic [23:0]  r_out;

   logic [31:0]  w_rot_value;
   eval_result_t w_eval;

   // Candidate for the current search step: value rotated left by 2*rot
   rotate_left32 u_rotate_left32 (
      .i_value  (r_value),
      .i_amount ({r_rot, 1'b0}),
      .o_value  (w_rot_value)
   );

   // Result of the current EVAL cycle. Only mode 1 can take more than one
   // cycle; it finishes on the first fitting rotation or on the last one.
   always_comb begin
      w_eval = '0;
      case (r_sel)
         SEL_MEM: begin
            w_eval.fin   = 1'b1;
            w_eval.valid = (r_value[31:12] == 20'h00000);
            w_eval.imm   = {12'h000, r_value[11:0]};
         end
         SEL_ROT: begin
            if (w_rot_value[31:8] == 24'h000000) begin
               w_eval.fin   = 1'b1;
               w_eval.valid = 1'b1;
               w_eval.imm   = {12'h000, r_rot, w_rot_value[7:0]};
            end else if (r_rot == c_ROT_LAST) begin
               w_eval.fin   = 1'b1;
               w_eval.valid = 1'b0;
               w_eval.imm   = 24'h000000;
            end
         end
         SEL_BRANCH: begin
            // Word aligned, and the top 7 bits are copies of bit 25 so the
            // 24-bit field sign-extends back to the original value.
            w_eval.fin   = 1'b1;
            w_eval.valid = (r_value[1:0] == 2'b00) &&
                           (r_value[31:25] == {7{r_value[25]}});
            w_eval.imm   = r_value[25:2];
         end
         default: begin
            w_eval.fin   = 1'b1;
            w_eval.valid = 1'b0;
            w_eval.imm   = 24'h000000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_rot   <= 4'd0;
         r_value <= 32'h0;
         r_sel   <= SEL_MEM;
         r_valid <= 1'b0;
         r_out   <= 24'h000000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_value <= in_value;
                  r_sel   <= immediate_sel;
                  r_rot   <= 4'd0;
                  r_state <= ST_EVAL;
               end
            end
            ST_EVAL: begin
               if (w_eval.fin) begin
                  r_valid <= w_eval.valid;
                  r_out   <= w_eval.imm;
                  r_state <= ST_DONE;
               end else begin
                  // fin is forced at c_ROT_LAST, so this never wraps
                  r_rot <= r_rot + 4'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy             = (r_state != ST_IDLE);
   assign done             = (r_state == ST_DONE);
   assign valid            = r_valid;
   assign out_immediate_24 = r_out;

endmodule

`default_nettype wire

// File: tb/tb_immediate_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_immediate_encoder                                       |
// | Description : Self-checking bench for immediate_encoder: directed vector |
// |               table plus reset-abort and held-start sequences.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_immediate_encoder;
   import immediate_defs::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] in_value;
   logic [1:0]  immediate_sel;
   logic        busy;
   logic        done;
   logic        valid;
   logic [23:0] out_immediate_24;

   int n_tests;
   int n_fail;
   int done_seen;
   logic mon_en;

   immediate_encoder #(.ROT_STEPS(16)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start            (start),
      .in_value         (in_value),
      .immediate_sel    (immediate_sel),
      .busy             (busy),
      .done             (done),
      .valid            (valid),
      .out_immediate_24 (out_immediate_24)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts done pulses while the reset-abort window is being watched
   always @(negedge clk) begin
      if (mon_en && done === 1'b1) done_seen++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  sel;
      logic [31:0] value;
      logic        exp_valid;
      logic [23:0] exp_out;
      int          exp_lat;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one request and waits (bounded) for done. lat counts edges from
   // the accepting edge (edge 1) to the edge after which done is high.
   task automatic run_op(input logic [1:0] sel, input logic [31:0] val,
                         output int lat, output logic v, output logic [23:0] o,
                         output logic busy_ok);
      @(negedge clk);
      start = 1'b1;
      immediate_sel = sel;
      in_value = val;
      @(posedge clk);
      #1;
      start = 1'b0;
      in_value = $urandom;
      immediate_sel = 2'($urandom);
      lat = 1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 40) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      v = valid;
      o = out_immediate_24;
   endtask

   initial begin
      int          lat;
      logic        v;
      logic [23:0] o;
      logic        bok;
      int          dones;
      logic        seen_done;
      logic        stable_ok;
      logic        idle_ok;
      logic        prev_idle;

      n_tests   = 0;
      n_fail    = 0;
      done_seen = 0;
      mon_en    = 1'b0;
      rst_n     = 1'b0;
      start     = 1'b0;
      in_value  = 32'h0;
      immediate_sel = 2'd0;

      vecs[0]  = '{SEL_MEM,    32'h00000ABC, 1'b1, 24'h000ABC, 2};
      vecs[1]  = '{SEL_MEM,    32'h00001000, 1'b0, 24'h000000, 2};
      vecs[2]  = '{SEL_MEM,    32'hFFFFFFFF, 1'b0, 24'h000FFF, 2};
      vecs[3]  = '{SEL_ROT,    32'hFF000000, 1'b1, 24'h0004FF, 6};
      vecs[4]  = '{SEL_ROT,    32'hF000000F, 1'b1, 24'h0002FF, 4};
      vecs[5]  = '{SEL_ROT,    32'h00000000, 1'b1, 24'h000000, 2};
      vecs[6]  = '{SEL_ROT,    32'h00000101, 1'b0, 24'h000000, 17};
      vecs[7]  = '{SEL_ROT,    32'h000000FF, 1'b1, 24'h0000FF, 2};
      vecs[8]  = '{SEL_ROT,    32'h000003FC, 1'b1, 24'h000FFF, 17};
      vecs[9]  = '{SEL_ROT,    32'h00000104, 1'b1, 24'h000F41, 17};
      vecs[10] = '{SEL_BRANCH, 32'hFFFFFFF8, 1'b1, 24'hFFFFFE, 2};
      vecs[11] = '{SEL_BRANCH, 32'h00000006, 1'b0, 24'h000001, 2};
      vecs[12] = '{SEL_BRANCH, 32'h02000000, 1'b0, 24'h800000, 2};
      vecs[13] = '{SEL_BRANCH, 32'h01FFFFFC, 1'b1, 24'h7FFFFF, 2};
      vecs[14] = '{SEL_RSVD,   32'h12345678, 1'b0, 24'h000000, 2};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy",  {31'h0, busy},  32'h0);
      check("reset_done",  {31'h0, done},  32'h0);
      check("reset_valid", {31'h0, valid}, 32'h0);
      check("reset_out",   {8'h0, out_immediate_24}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Directed vectors
      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i].sel, vecs[i].value, lat, v, o, bok);
         check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_valid", i), {31'h0, v}, {31'h0, vecs[i].exp_valid});
         check($sformatf("v%0d_out", i), {8'h0, o}, {8'h0, vecs[i].exp_out});
         check($sformatf("v%0d_busy_while_eval", i), {31'h0, bok}, 32'h1);
         if (vecs[i].exp_valid)
            check($sformatf("v%0d_roundtrip", i), extend_immediate(vecs[i].sel, o), vecs[i].value);
         // Following IDLE cycle: pulse gone, results held
         @(posedge clk);
         #1;
         check($sformatf("v%0d_done_pulse_end", i), {30'h0, busy, done}, 32'h0);
         check($sformatf("v%0d_hold_valid", i), {31'h0, valid}, {31'h0, vecs[i].exp_valid});
         check($sformatf("v%0d_hold_out", i), {8'h0, out_immediate_24}, {8'h0, vecs[i].exp_out});
      end

      // Reset in the middle of a mode-1 search (rot = 7)
      run_op(SEL_ROT, 32'hFF000000, lat, v, o, bok);
      check("pre_reset_out", {8'h0, o}, 32'h000004FF);
      @(negedge clk);
      start = 1'b1;
      immediate_sel = SEL_ROT;
      in_value = 32'h00000101;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      done_seen = 0;
      mon_en = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy",  {31'h0, busy},  32'h0);
      check("abort_done",  {31'h0, done},  32'h0);
      check("abort_valid", {31'h0, valid}, 32'h0);
      check("abort_out",   {8'h0, out_immediate_24}, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("abort_no_done", done_seen, 0);
      run_op(SEL_ROT, 32'hF000000F, lat, v, o, bok);
      check("post_reset_latency", lat, 4);
      check("post_reset_valid", {31'h0, v}, 32'h1);
      check("post_reset_out", {8'h0, o}, 32'h000002FF);

      // Start held high: accepted only in IDLE, one done per accept
      @(negedge clk);
      start = 1'b1;
      immediate_sel = SEL_MEM;
      in_value = 32'h00000ABC;
      dones = 0;
      seen_done = 1'b0;
      stable_ok = 1'b1;
      idle_ok = 1'b1;
      prev_idle = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) begin
            dones++;
            seen_done = 1'b1;
         end
         if (seen_done && (valid !== 1'b1 || out_immediate_24 !== 24'h000ABC))
            stable_ok = 1'b0;
         if (busy !== 1'b1 && prev_idle) idle_ok = 1'b0;
         prev_idle = (busy !== 1'b1);
      end
      @(negedge clk);
      start = 1'b0;
      check("held_start_dones", dones, 4);
      check("held_start_outputs_stable", {31'h0, stable_ok}, 32'h1);
      check("held_start_single_idle", {31'h0, idle_ok}, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      check("held_start_final_idle", {31'h0, busy}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
